data_cache_responder: RTL
=========================

# data_cache_responder

- Responder end of the MEM-stage data-memory protocol: serves the `readM`/`writeM`/`address`/`data` requests issued by the pipeline's MEM stage.
- Contains a direct-mapped, write-through, no-write-allocate data cache of 4 lines × 4 words.
- On misses and on every write it initiates line fills and word writes to backing memory through a separate handshake port.
- Signals completion with a one-cycle `ready` pulse and exports hit/miss counters.

## Interface
- WORD_SIZE, 16, data/address width
- LINE_WORDS, 4, words per line (fixed; offset = address[1:0])
- NUM_LINES, 4, cache lines (fixed; index = address[3:2], tag = address[15:4])
- clk  input  1  single clock, all state updates on posedge
- reset  input  1  synchronous, active-high; sampled at posedge clk
- readM  input  1  read request from MEM stage
- writeM  input  1  write request from MEM stage
- address  input  16  word address of request
- data  inout  16  write data in; read data driven by this block only while `ready` is high for a read, else high-Z
- ready  output  1  one-cycle completion pulse
- mem_readM  output  1  backing-memory line read request
- mem_writeM  output  1  backing-memory word write request
- mem_address  output  16  line-aligned address (address[1:0]=0) for fills; full word address for writes
- mem_wdata  output  16  word to write
- mem_rdata  input  64  fill line, word 0 in bits [15:0]
- mem_ready  input  1  one-cycle backing-memory completion pulse
- hit_count  output  16  saturating access-hit counter
- miss_count  output  16  saturating access-miss counter

## Operation
- States: IDLE, FILL, WRITE, RESP.
- IDLE: sample request at posedge.
  - Latch address, and data if write; inputs are ignored until the following RESP.
  - readM and writeM both high: treated as a read.
- Read hit (valid and tag match): increment hit_count → RESP.
- Read miss: increment miss_count → FILL.
- FILL:
  - Hold mem_readM=1 and mem_address = {tag, index, 2'b00}.
  - On mem_ready: write mem_rdata into the line, set valid, store tag → RESP.
- Write:
  - Hit: increment hit_count; the cached word is updated at acceptance.
  - Miss: increment miss_count; no allocation, no line change.
  - Both cases → WRITE.
- WRITE: hold mem_writeM=1, mem_address = latched address, mem_wdata = latched data; on mem_ready → RESP.
- RESP:
  - ready=1 for exactly one cycle.
  - For a read, data = selected cached word.
  - → IDLE.
- mem_readM and mem_writeM are never high simultaneously.
- mem_ready arriving in IDLE or RESP is ignored.
- Counters saturate at 16'hFFFF and do not wrap.
- Reset, in any state including mid-FILL/WRITE:
  - state=IDLE, all valid bits cleared.
  - ready, mem_readM, mem_writeM = 0; mem_address, mem_wdata = 0.
  - hit_count, miss_count = 0; data high-Z.
  - Any in-flight request is dropped; a late mem_ready is ignored.

## Timing
- Request accepted at posedge E0.
- Read hit: ready high in the cycle after E0 (latency 1).
- Read miss: mem_readM high from E0 until the posedge Ek where mem_ready=1; ready high in the cycle after Ek.
- Write (hit or miss): mem_writeM high from E0 through Ek; ready in the cycle after Ek.
- Requester must drop or change the request by the posedge ending the ready cycle. The next request is sampled at the following posedge, giving a minimum one-cycle gap between ready and the next acceptance.
- Tag, valid and line data update at the same posedge that leaves FILL. A read of the same line accepted next is a hit.
- Write-hit word update is visible to a read accepted after RESP.

## Test plan
- Cold read: reset, memory word 0x0012 = 0xBEEF, 3-cycle mem latency, read 0x0012 → one FILL with mem_address=0x0010; ready with data=0xBEEF; miss_count=1, hit_count=0.
- Read hit: then read 0x0013 → no mem_readM; ready one cycle after acceptance; data = memory[0x0013]; hit_count=1.
- Write hit: write 0x1234 to 0x0011 → mem_writeM with mem_wdata=0x1234; ready after mem_ready; read 0x0011 → hit, data=0x1234.
- Write miss, no-allocate: write 0x5555 to 0x0100 → miss_count increments, mem_writeM issued; read 0x0100 → miss, FILL issued.
- Conflict eviction: read 0x0000, then 0x0040 (same index 0), then 0x0000 → three misses, three fills with correct data each.
- Reset mid-FILL: assert reset while mem_readM=1 → next cycle all outputs 0; a mem_ready pulse two cycles later produces no ready; the next read of the same address misses.

Source files
------------

// File: rtl/data_cache_responder.sv
// Data-memory responder for the MEM stage: a 4x4-word direct-mapped, write-through,
// no-write-allocate cache that fills lines and writes words through a backing-memory handshake.
module data_cache_responder #(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            readM,
    input  logic                            writeM,
    input  logic [WORD_SIZE-1:0]            address,
    inout  wire  [WORD_SIZE-1:0]            data,
    output logic                            ready,
    output logic                            mem_readM,
    output logic                            mem_writeM,
    output logic [WORD_SIZE-1:0]            mem_address,
    output logic [WORD_SIZE-1:0]            mem_wdata,
    input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata,
    input  logic                            mem_ready,
    output logic [15:0]                     hit_count,
    output logic [15:0]                     miss_count
);

    localparam int TAG_W = WORD_SIZE - 4;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

    state_t                 state_q, state_d;
    logic [WORD_SIZE-1:0]   addr_q;
    logic [WORD_SIZE-1:0]   wdata_q;
    logic                   isRead_q;
    logic [NUM_LINES-1:0]   valid_q;
    logic [TAG_W-1:0]       tag_q   [NUM_LINES];
    logic [WORD_SIZE-1:0]   words_q [NUM_LINES][LINE_WORDS];
    logic [15:0]            hitCount_q, missCount_q;

    logic [1:0]             reqIdx, reqOff, curIdx, curOff;
    logic [TAG_W-1:0]       reqTag;
    logic                   reqHit, accept;
    logic [WORD_SIZE-1:0]   rdWord;

    assign reqIdx = address[3:2];
    assign reqOff = address[1:0];
    assign reqTag = address[WORD_SIZE-1:4];
    assign reqHit = valid_q[reqIdx] && (tag_q[reqIdx] == reqTag);
    assign accept = (state_q == IDLE) && (readM || writeM);

    assign curIdx = addr_q[3:2];
    assign curOff = addr_q[1:0];
    assign rdWord = words_q[curIdx][curOff];

    // A simultaneous readM/writeM is served as a read, so only readM decides the direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (readM) begin
                        state_d = reqHit ? RESP : FILL;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            FILL:    if (mem_ready) state_d = RESP;
            WRITE:   if (mem_ready) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready       = (state_q == RESP);
        mem_readM   = (state_q == FILL);
        mem_writeM  = (state_q == WRITE);
        mem_address = '0;
        mem_wdata   = '0;
        if (state_q == FILL) begin
            mem_address = {addr_q[WORD_SIZE-1:2], 2'b00};
        end else if (state_q == WRITE) begin
            mem_address = addr_q;
            mem_wdata   = wdata_q;
        end
    end

    // Cache arrays and counters; a write hit patches the cached word on the accepting edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            isRead_q    <= 1'b0;
            hitCount_q  <= '0;
            missCount_q <= '0;
        end else begin
            if (accept) begin
                addr_q   <= address;
                isRead_q <= readM;
                if (!readM) begin
                    wdata_q <= data;
                end
                if (reqHit) begin
                    if (hitCount_q != 16'hFFFF) hitCount_q <= hitCount_q + 16'd1;
                    if (!readM) begin
                        words_q[reqIdx][reqOff] <= data;
                    end
                end else begin
                    if (missCount_q != 16'hFFFF) missCount_q <= missCount_q + 16'd1;
                end
            end
            if ((state_q == FILL) && mem_ready) begin
                valid_q[curIdx] <= 1'b1;
                tag_q[curIdx]   <= addr_q[WORD_SIZE-1:4];
                for (int w = 0; w < LINE_WORDS; w++) begin
                    words_q[curIdx][w] <= mem_rdata[w*WORD_SIZE +: WORD_SIZE];
                end
            end
        end
    end

    assign hit_count  = hitCount_q;
    assign miss_count = missCount_q;

    assign data = (ready && isRead_q) ? rdWord : {WORD_SIZE{1'bz}};

endmodule
